// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Provides the fetch FSM state enum, default halt encoding and redirect-type codes.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_HALT_CODE = 32'hFFFF_FFFF;

    localparam logic REL = 1'b1;
    localparam logic ABS = 1'b0;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential increment, relative branch or absolute jump.
// Ports: cur_pc/ins_pc in, redir/rel/off/target in (redirect request), next_pc out.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int OFF_W = 16
) (
    input  logic [PC_W-1:0]  cur_pc,
    input  logic [PC_W-1:0]  ins_pc,
    input  logic             redir,
    input  logic             rel,
    input  logic [OFF_W-1:0] off,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  next_pc
);

    // Sign-extend into a width that covers both PC_W and OFF_W, then keep the
    // low PC_W bits so the arithmetic stays modulo 2^PC_W whatever the widths.
    logic [PC_W+OFF_W-1:0] off_wide;
    logic [PC_W-1:0]       off_ext;

    assign off_wide = {{PC_W{off[OFF_W-1]}}, off};
    assign off_ext  = off_wide[PC_W-1:0];

    always_comb begin
        next_pc = cur_pc + PC_W'(1);
        if (redir) begin
            if (rel == REL) begin
                // Relative branches are taken from the instruction after the branch.
                next_pc = ins_pc + PC_W'(1) + off_ext;
            end else begin
                next_pc = target;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures insmem data into an output register.
// Ports: clk, reset (async active-low), pc/inscode to insmem, ins_out/ins_pc/ins_valid/ins_ready, redir_*, halted.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                PC_W      = 32,
    parameter int                INS_W     = 32,
    parameter int                OFF_W     = 16,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [INS_W-1:0]  HALT_CODE = INS_W'(DEF_HALT_CODE)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PC_W-1:0]  pc,
    input  logic [INS_W-1:0] inscode,
    output logic [INS_W-1:0] ins_out,
    output logic [PC_W-1:0]  ins_pc,
    output logic             ins_valid,
    input  logic             ins_ready,
    input  logic             redir_valid,
    input  logic             redir_rel,
    input  logic [OFF_W-1:0] redir_off,
    input  logic [PC_W-1:0]  redir_target,
    output logic             halted
);

    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HALT = HALT;

    logic [1:0]      state;
    logic            cap;
    logic            take_redir;
    logic [PC_W-1:0] next_pc;

    // A redirect only makes sense against an instruction that is actually held.
    assign take_redir = redir_valid && ins_valid;
    assign cap        = !ins_valid || ins_ready;

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next (
        .cur_pc  (pc),
        .ins_pc  (ins_pc),
        .redir   (take_redir),
        .rel     (redir_rel),
        .off     (redir_off),
        .target  (redir_target),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            ins_out   <= '0;
            ins_pc    <= '0;
            ins_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (take_redir) begin
                        // Word at pc is wrong-path; drop it and steer pc.
                        pc <= next_pc;
                        if (ins_ready) begin
                            ins_valid <= 1'b0;
                        end
                    end else if (cap) begin
                        ins_out   <= inscode;
                        ins_pc    <= pc;
                        ins_valid <= 1'b1;
                        if (inscode == HALT_CODE) begin
                            state <= ST_HALT;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    if (ins_valid && ins_ready) begin
                        ins_valid <= 1'b0;
                        halted    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule
